// File: rtl/lcd_write_fsm.sv
// lcd_write_fsm
//   Configures a character LCD after the power-on init sequencer reports done,
//   then streams bytes (commands or characters) from a text writer onto the
//   4-bit LCD bus. Each byte goes out as two LCD_E-strobed nibbles, upper nibble
//   first. The required inter-nibble and post-byte delays are timed with a
//   shared cycle counter.
//
//   Parameters (cycles at 50 MHz):
//     SETUP_CYC     data/RS valid before LCD_E rises
//     PULSE_CYC     LCD_E high width
//     HOLD_CYC      data held after LCD_E falls
//     GAP_CYC       idle between upper and lower nibble
//     CMD_WAIT_CYC  wait after an ordinary byte
//     CLR_WAIT_CYC  wait after Clear (0x01) / Home (0x02) commands
//
//   Ports:
//     clk       in   system clock, rising edge
//     reset     in   asynchronous, active-high reset
//     enable    in   init-sequence-complete flag (sampled only while waiting)
//     wr_valid  in   byte offered by the writer
//     wr_data   in   byte to write
//     wr_rs     in   0 = command, 1 = character data
//     wr_ready  out  block accepts a byte this cycle
//     cfg_done  out  configuration finished, sticky until reset
//     SF_D      out  LCD bus, nibble on [11:8], [7:0] always 0
//     LCD_E     out  LCD enable strobe
//     LCD_RS    out  register select
//     LCD_RW    out  always 0 (write only)
module lcd_write_fsm #(
  parameter int SETUP_CYC    = 2,
  parameter int PULSE_CYC    = 12,
  parameter int HOLD_CYC     = 1,
  parameter int GAP_CYC      = 50,
  parameter int CMD_WAIT_CYC = 2000,
  parameter int CLR_WAIT_CYC = 82000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        wr_valid,
  input  logic [7:0]  wr_data,
  input  logic        wr_rs,
  output logic        wr_ready,
  output logic        cfg_done,
  output logic [11:0] SF_D,
  output logic        LCD_E,
  output logic        LCD_RS,
  output logic        LCD_RW
);

  localparam int CNT_W = 17;
  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [3:0] {
    S_WAIT_INIT,
    S_CFG_LOAD,
    S_IDLE,
    S_U_SETUP,
    S_U_PULSE,
    S_U_HOLD,
    S_GAP,
    S_L_SETUP,
    S_L_PULSE,
    S_L_HOLD,
    S_POST_WAIT
  } state_e;

  // Configuration commands issued in order once init is done:
  // Function Set, Entry Mode, Display On, Clear.
  function automatic logic [7:0] cfg_byte(input logic [1:0] k);
    case (k)
      2'd0:    cfg_byte = 8'h28;
      2'd1:    cfg_byte = 8'h06;
      2'd2:    cfg_byte = 8'h0C;
      default: cfg_byte = 8'h01;
    endcase
  endfunction

  state_e     state_q, state_d;
  cnt_t       cnt_q, cnt_d;
  logic [1:0] k_q, k_d;
  logic [7:0] byte_q, byte_d;
  logic       rs_q, rs_d;
  logic       cfg_done_q, cfg_done_d;

  // Registered bus outputs, decoded from the next state so they line up
  // exactly with the state they belong to.
  logic [3:0] nib_q, nib_d;
  logic       e_q, e_d;
  logic       rs_o_q, rs_o_d;
  logic       ready_q, ready_d;

  logic       is_clr;
  logic       timed;
  cnt_t       last_cnt;
  logic       tdone;

  // Clear and Home need the long post-byte wait; a character 0x01/0x02 does not.
  assign is_clr = !rs_q && ((byte_q == 8'h01) || (byte_q == 8'h02));

  // Terminal count of the current timed state.
  always_comb begin
    last_cnt = '0;
    timed    = 1'b1;
    case (state_q)
      S_U_SETUP, S_L_SETUP: last_cnt = cnt_t'(SETUP_CYC - 1);
      S_U_PULSE, S_L_PULSE: last_cnt = cnt_t'(PULSE_CYC - 1);
      S_U_HOLD,  S_L_HOLD:  last_cnt = cnt_t'(HOLD_CYC - 1);
      S_GAP:                last_cnt = cnt_t'(GAP_CYC - 1);
      S_POST_WAIT:          last_cnt = is_clr ? cnt_t'(CLR_WAIT_CYC - 1)
                                              : cnt_t'(CMD_WAIT_CYC - 1);
      default:              timed    = 1'b0;
    endcase
  end

  assign tdone = timed && (cnt_q == last_cnt);

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    byte_d     = byte_q;
    rs_d       = rs_q;
    cfg_done_d = cfg_done_q;
    cnt_d      = '0;

    case (state_q)
      S_WAIT_INIT: begin
        if (enable) state_d = S_CFG_LOAD;
      end
      S_CFG_LOAD: begin
        byte_d  = cfg_byte(k_q);
        rs_d    = 1'b0;
        state_d = S_U_SETUP;
      end
      S_IDLE: begin
        if (wr_valid && ready_q) begin
          byte_d  = wr_data;
          rs_d    = wr_rs;
          state_d = S_U_SETUP;
        end
      end
      S_U_SETUP: if (tdone) state_d = S_U_PULSE;
      S_U_PULSE: if (tdone) state_d = S_U_HOLD;
      S_U_HOLD:  if (tdone) state_d = S_GAP;
      S_GAP:     if (tdone) state_d = S_L_SETUP;
      S_L_SETUP: if (tdone) state_d = S_L_PULSE;
      S_L_PULSE: if (tdone) state_d = S_L_HOLD;
      S_L_HOLD:  if (tdone) state_d = S_POST_WAIT;
      S_POST_WAIT: begin
        if (tdone) begin
          if (!cfg_done_q) begin
            if (k_q == 2'd3) begin
              cfg_done_d = 1'b1;
              state_d    = S_IDLE;
            end else begin
              k_d     = k_q + 2'd1;
              state_d = S_CFG_LOAD;
            end
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_WAIT_INIT;
    endcase

    // Counter restarts on every state entry and only runs in timed states.
    if (timed && (state_d == state_q)) cnt_d = cnt_q + cnt_t'(1);
  end

  // Output decode from the next state
  always_comb begin
    nib_d   = 4'h0;
    e_d     = 1'b0;
    rs_o_d  = rs_d;
    ready_d = 1'b0;
    case (state_d)
      S_U_SETUP, S_U_HOLD: nib_d = byte_d[7:4];
      S_U_PULSE: begin
        nib_d = byte_d[7:4];
        e_d   = 1'b1;
      end
      S_L_SETUP, S_L_HOLD: nib_d = byte_d[3:0];
      S_L_PULSE: begin
        nib_d = byte_d[3:0];
        e_d   = 1'b1;
      end
      S_WAIT_INIT: rs_o_d = 1'b0;
      S_IDLE: begin
        rs_o_d  = 1'b0;
        ready_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_WAIT_INIT;
      cnt_q      <= '0;
      k_q        <= '0;
      byte_q     <= '0;
      rs_q       <= 1'b0;
      cfg_done_q <= 1'b0;
      nib_q      <= '0;
      e_q        <= 1'b0;
      rs_o_q     <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      k_q        <= k_d;
      byte_q     <= byte_d;
      rs_q       <= rs_d;
      cfg_done_q <= cfg_done_d;
      nib_q      <= nib_d;
      e_q        <= e_d;
      rs_o_q     <= rs_o_d;
      ready_q    <= ready_d;
    end
  end

  assign SF_D     = {nib_q, 8'h00};
  assign LCD_E    = e_q;
  assign LCD_RS   = rs_o_q;
  assign LCD_RW   = 1'b0;
  assign wr_ready = ready_q;
  assign cfg_done = cfg_done_q;

endmodule

// File: tb/tb_lcd_write_fsm.sv
// Bench for lcd_write_fsm. Wait times are scaled down so the whole run stays
// short; the reference model derives every expected duration from the same
// parameter values using the protocol rules.
module tb_lcd_write_fsm;

  localparam int SETUP = 2;
  localparam int PULSE = 12;
  localparam int HOLD  = 1;
  localparam int GAP   = 50;
  localparam int CMD_W = 200;
  localparam int CLR_W = 1000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        wr_valid = 1'b0;
  logic [7:0]  wr_data = 8'h00;
  logic        wr_rs = 1'b0;
  logic        wr_ready, cfg_done, LCD_E, LCD_RS, LCD_RW;
  logic [11:0] SF_D;

  lcd_write_fsm #(
    .SETUP_CYC(SETUP), .PULSE_CYC(PULSE), .HOLD_CYC(HOLD), .GAP_CYC(GAP),
    .CMD_WAIT_CYC(CMD_W), .CLR_WAIT_CYC(CLR_W)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .wr_valid(wr_valid),
    .wr_data(wr_data), .wr_rs(wr_rs), .wr_ready(wr_ready), .cfg_done(cfg_done),
    .SF_D(SF_D), .LCD_E(LCD_E), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;
  int viol    = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: cycles a byte keeps the block busy (first upper-nibble
  // setup cycle up to, not including, the next IDLE cycle).
  function automatic int byte_cycles(input logic [7:0] b, input logic rs);
    int post;
    post = (!rs && (b == 8'h01 || b == 8'h02)) ? CLR_W : CMD_W;
    return 2 * (SETUP + PULSE + HOLD) + GAP + post;
  endfunction

  // Bus monitor: one record per completed LCD_E pulse.
  typedef struct {
    logic [3:0] nib;
    logic       rs;
    int         rise;
    int         width;
  } pulse_t;

  pulse_t     pq[$];
  logic       e_prev = 1'b0;
  logic [3:0] cur_nib = 4'h0;
  logic       cur_rs = 1'b0;
  int         cur_rise = 0;

  always @(negedge clk) begin
    e_prev <= LCD_E;
    if (LCD_E && !e_prev) begin
      cur_nib  <= SF_D[11:8];
      cur_rs   <= LCD_RS;
      cur_rise <= cyc;
    end
    if (!LCD_E && e_prev)
      pq.push_back('{nib: cur_nib, rs: cur_rs, rise: cur_rise, width: cyc - cur_rise});
    if (LCD_E && e_prev && (SF_D[11:8] !== cur_nib || LCD_RS !== cur_rs))
      viol <= viol + 1;
    if (SF_D[7:0] !== 8'h00 || LCD_RW !== 1'b0)
      viol <= viol + 1;
  end

  task automatic wait_ready(input string tag);
    bit ok = 0;
    for (int i = 0; i < 5000; i++) begin
      if (wr_ready) begin ok = 1; break; end
      @(negedge clk);
    end
    chk({tag, "_rdy_wait"}, ok, 1);
  endtask

  task automatic check_byte(input logic [7:0] b, input logic rs, input string tag,
                            output int rise_hi);
    pulse_t p[2];
    for (int i = 0; i < 2; i++) begin
      if (pq.size() == 0) begin
        chk({tag, "_pulse_present"}, 0, 1);
        p[i] = '{nib: 4'h0, rs: 1'b0, rise: 0, width: 0};
      end else begin
        p[i] = pq.pop_front();
      end
    end
    chk({tag, "_nib_hi"},   p[0].nib, b[7:4]);
    chk({tag, "_nib_lo"},   p[1].nib, b[3:0]);
    chk({tag, "_rs_hi"},    p[0].rs, rs);
    chk({tag, "_rs_lo"},    p[1].rs, rs);
    chk({tag, "_width_hi"}, p[0].width, PULSE);
    chk({tag, "_width_lo"}, p[1].width, PULSE);
    chk({tag, "_nib_gap"},  p[1].rise - p[0].rise, PULSE + HOLD + GAP + SETUP);
    rise_hi = p[0].rise;
  endtask

  task automatic run_config(input string tag);
    logic [7:0] cfg[4];
    int  t0, t1, exp_len, hi, prev_hi;
    bit  found, seen_done;
    cfg = '{8'h28, 8'h06, 8'h0C, 8'h01};
    @(negedge clk);
    enable = 1'b1;
    found = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (SF_D[11:8] == 4'h2) begin found = 1; break; end
    end
    chk({tag, "_start"}, found, 1);
    t0 = cyc;
    enable = 1'b0;   // later deassertion must not matter
    found = 0;
    seen_done = 0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (wr_ready) begin found = 1; break; end
      if (cfg_done) seen_done = 1;
    end
    t1 = cyc;
    chk({tag, "_ready"}, found, 1);
    chk({tag, "_done_early"}, seen_done, 0);
    chk({tag, "_done"}, cfg_done, 1);
    exp_len = 3;
    for (int k = 0; k < 4; k++) exp_len += byte_cycles(cfg[k], 1'b0);
    chk({tag, "_len"}, t1 - t0, exp_len);
    prev_hi = 0;
    for (int k = 0; k < 4; k++) begin
      check_byte(cfg[k], 1'b0, $sformatf("%s_b%0d", tag, k), hi);
      if (k > 0)
        chk($sformatf("%s_spacing%0d", tag, k), hi - prev_hi, byte_cycles(cfg[k-1], 1'b0) + 1);
      prev_hi = hi;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic rs, input string tag);
    int  ta, n, hi;
    bit  ok;
    wait_ready(tag);
    wr_valid = 1'b1;
    wr_data  = b;
    wr_rs    = rs;
    @(negedge clk);
    ta = cyc;
    wr_valid = 1'b0;
    wr_data  = ~b;
    wr_rs    = ~rs;
    chk({tag, "_bus_nib"}, SF_D[11:8], b[7:4]);
    chk({tag, "_bus_rs"},  LCD_RS, rs);
    chk({tag, "_rdy_drop"}, wr_ready, 0);
    n = 1;
    ok = 0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (wr_ready) begin ok = 1; break; end
      n++;
    end
    chk({tag, "_rdy_back"}, ok, 1);
    chk({tag, "_busy_len"}, n, byte_cycles(b, rs));
    check_byte(b, rs, tag, hi);
    chk({tag, "_e_latency"}, hi - ta, SETUP);
  endtask

  task automatic busy_test();
    logic [7:0] bq[$];
    logic       rq[$];
    int         aq[$];
    int         hi;
    wait_ready("busy");
    wr_valid = 1'b1;
    for (int i = 0; i < 20000 && aq.size() < 4; i++) begin
      wr_data = 8'($urandom);
      wr_rs   = 1'($urandom_range(0, 1));
      if (wr_ready) begin
        bq.push_back(wr_data);
        rq.push_back(wr_rs);
        aq.push_back(cyc);
      end
      @(negedge clk);
    end
    wr_valid = 1'b0;
    chk("busy_accepts", aq.size(), 4);
    wait_ready("busy_end");
    for (int k = 0; k < aq.size(); k++) begin
      check_byte(bq[k], rq[k], $sformatf("busy%0d", k), hi);
      chk($sformatf("busy%0d_latency", k), hi - aq[k], SETUP + 1);
      if (k > 0)
        chk($sformatf("busy%0d_spacing", k), aq[k] - aq[k-1], byte_cycles(bq[k-1], rq[k-1]) + 1);
    end
  endtask

  task automatic mid_reset_test();
    bit found = 0;
    wait_ready("mid");
    wr_valid = 1'b1;
    wr_data  = 8'h55;
    wr_rs    = 1'b1;
    @(negedge clk);
    wr_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (LCD_E) begin found = 1; break; end
      @(negedge clk);
    end
    chk("mid_e_high", found, 1);
    #3;
    reset  = 1'b1;
    enable = 1'b0;
    #1;
    chk("mid_rst_e",     LCD_E, 0);
    chk("mid_rst_done",  cfg_done, 0);
    chk("mid_rst_ready", wr_ready, 0);
    chk("mid_rst_sfd",   SF_D, 12'h000);
    chk("mid_rst_rs",    LCD_RS, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    pq.delete();
    chk("mid_rel_ready", wr_ready, 0);
    run_config("cfg2");
  endtask

  initial begin
    #1_200_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    logic       rs;

    // Reset held with enable low: everything quiet.
    repeat (3) @(negedge clk);
    chk("rst_sfd",   SF_D, 12'h000);
    chk("rst_e",     LCD_E, 0);
    chk("rst_rs",    LCD_RS, 0);
    chk("rst_rw",    LCD_RW, 0);
    chk("rst_ready", wr_ready, 0);
    chk("rst_done",  cfg_done, 0);
    reset = 1'b0;
    wr_valid = 1'b1;   // offered while waiting for init: must be ignored
    repeat (50) @(negedge clk);
    wr_valid = 1'b0;
    chk("wait_ready",  wr_ready, 0);
    chk("wait_done",   cfg_done, 0);
    chk("wait_pulses", pq.size(), 0);
    chk("wait_sfd",    SF_D, 12'h000);

    run_config("cfg");

    send_byte(8'h41, 1'b1, "char_A");
    send_byte(8'h01, 1'b0, "clear");
    send_byte(8'h01, 1'b1, "char_01");
    send_byte(8'h02, 1'b0, "home");

    for (int i = 0; i < 10; i++) begin
      b  = 8'($urandom);
      rs = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) begin
        b  = 8'($urandom_range(1, 2));
        rs = 1'b0;
      end
      repeat ($urandom_range(0, 4)) @(negedge clk);
      send_byte(b, rs, $sformatf("rnd%0d", i));
    end

    busy_test();
    mid_reset_test();

    chk("bus_static", viol, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
